// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and types shared by the rotation and vectoring CORDIC blocks.
package cordic_pkg;
    typedef logic signed [15:0] angle_t;
    typedef enum logic [1:0] {IDLE, ROTATE, COMP, DONE} state_t;
    localparam logic [15:0] INV_GAIN = 16'h4DBA;
    localparam logic [15:0] ARC_TAN [15] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0145, 16'h00A2, 16'h0051,
        16'h0028, 16'h0014, 16'h000A, 16'h0005, 16'h0002, 16'h0001, 16'h0000
    };
endpackage

// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if: valid/ready vector input and magnitude/angle result channel.
interface cordic_vectoring_if;
    import cordic_pkg::*;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0] x_in, y_in;
    logic        [17:0] magnitude;
    angle_t             angle;
    modport master (output in_valid, x_in, y_in, out_ready,
                    input  in_ready, out_valid, magnitude, angle);
    modport slave  (input  in_valid, x_in, y_in, out_ready,
                    output in_ready, out_valid, magnitude, angle);
endinterface

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: scales the raw CORDIC x by 1/K (Q1.15) with round-to-nearest.
module cordic_gain_comp
    import cordic_pkg::*;
(
    input  logic signed [17:0] x_i,
    output logic signed [17:0] mag_o
);
    assign mag_o = 18'((x_i * $signed({1'b0, INV_GAIN}) + 35'sd16384) >>> 15);
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC returning magnitude and atan2 phase.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that removes the CORDIC gain.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 15
) (
    input logic               clock,
    input logic               reset,
    cordic_vectoring_if.slave bus
);
    state_t             state_q, state_d;
    logic signed [17:0] x_q, x_d, y_q, y_d, sx, sy, xe, ye;
    angle_t             z_q, z_d;
    logic        [3:0]  i_q, i_d;
    logic               zero_q, zero_d, neg;

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [17:0] comp_x;
    cordic_gain_comp u_comp (.x_i(x_q), .mag_o(comp_x));
    localparam state_t LAST = COMP;
`else
    localparam state_t LAST = DONE;
`endif

    assign xe  = {{2{bus.x_in[15]}}, bus.x_in};
    assign ye  = {{2{bus.y_in[15]}}, bus.y_in};
    assign neg = bus.x_in[15];
    assign sx  = x_q >>> i_q;
    assign sy  = y_q >>> i_q;

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.magnitude = zero_q ? '0 : x_q;
    assign bus.angle     = zero_q ? '0 : z_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                // Left half-plane is pre-rotated by 180 deg so iterations converge.
                x_d     = neg ? -xe : xe;
                y_d     = neg ? -ye : ye;
                z_d     = neg ? angle_t'(16'h8000) : '0;
                i_d     = '0;
                zero_d  = bus.x_in == '0 && bus.y_in == '0;
                state_d = ROTATE;
            end
            ROTATE: begin
                x_d = y_q[17] ? x_q - sy : x_q + sy;
                y_d = y_q[17] ? y_q + sx : y_q - sx;
                z_d = y_q[17] ? z_q - ARC_TAN[i_q] : z_q + ARC_TAN[i_q];
                i_d = i_q + 4'd1;
                if (i_q == 4'(ITERATIONS - 1)) state_d = LAST;
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                x_d     = comp_x;
                state_d = DONE;
            end
`endif
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed and random vectors checked against a real-arithmetic atan2/hypot model.
module tb_cordic_vectoring;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cordic_vectoring_if bus ();
    cordic_vectoring #(.ITERATIONS(15)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT  = 16;
    localparam real GAIN = 1.0;
    localparam int  MTOL = 4;
`else
    localparam int  LAT  = 15;
    localparam real GAIN = 1.6467602581;
    localparam int  MTOL = 8;
`endif

    function automatic int exp_ang(int x, int y);
        real a = $atan2(real'(y), real'(x)) * 32768.0 / 3.14159265358979;
        return $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
    endfunction

    function automatic int exp_mag(int x, int y);
        return $rtoi($sqrt(real'(x) * x + real'(y) * y) * GAIN + 0.5);
    endfunction

    task automatic chk_eq(string tag, int got, int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(string tag, int got, int exp, int tol, bit wrap);
        int d = got - exp;
        logic signed [15:0] ds = 16'(d);
        bit ok;
        if (wrap) d = ds;
        ok = d >= -tol && d <= tol;
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, output int lat);
        @(negedge clock);
        bus.x_in = x;
        bus.y_in = y;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clock);
            #1 lat++;
        end
    endtask

    task automatic consume();
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run(input logic signed [15:0] x, input logic signed [15:0] y, input int mtol);
        int lat;
        string t = $sformatf("(%0d,%0d)", x, y);
        send(x, y, lat);
        chk_eq({"latency", t}, lat, LAT);
        if (x == 0 && y == 0) begin
            chk_eq({"zero_angle", t}, int'(bus.angle), 0);
            chk_eq({"zero_mag", t}, int'(bus.magnitude), 0);
        end else begin
            chk_near({"angle", t}, int'(bus.angle), exp_ang(x, y), 3, 1'b1);
            chk_near({"mag", t}, int'(bus.magnitude), exp_mag(x, y), mtol, 1'b0);
        end
        consume();
        chk_eq({"in_ready_after", t}, int'(bus.in_ready), 1);
        chk_eq({"out_valid_after", t}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int lat;
        int m;
        int a;
        logic signed [15:0] rx, ry;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_eq("rst_out_valid", int'(bus.out_valid), 0);
        chk_eq("rst_in_ready", int'(bus.in_ready), 1);
        chk_eq("rst_mag", int'(bus.magnitude), 0);
        chk_eq("rst_angle", int'(bus.angle), 0);
        @(negedge clock) reset = 1'b1;

        run(16'sh4000, 16'sh0000, 4);
        run(16'sh0000, 16'sh4000, MTOL);
        run(-16'sh4000, 16'sh0000, MTOL);
        run(16'sh4000, 16'sh4000, MTOL);
        run(-16'sd32768, -16'sd32768, MTOL);
        run(16'sh0000, 16'sh0000, 0);
        run(16'sh7FFF, -16'sh0001, MTOL);

        send(16'sh3000, -16'sh2000, lat);
        chk_eq("stall_latency", lat, LAT);
        m = int'(bus.magnitude);
        a = int'(bus.angle);
        chk_near("stall_angle", a, exp_ang(16'sh3000, -16'sh2000), 3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.x_in = 16'sh0123;
            bus.y_in = 16'sh0456;
            @(posedge clock);
            #1;
            chk_eq($sformatf("stall_valid%0d", k), int'(bus.out_valid), 1);
            chk_eq($sformatf("stall_ready%0d", k), int'(bus.in_ready), 0);
            chk_eq($sformatf("stall_mag%0d", k), int'(bus.magnitude), m);
            chk_eq($sformatf("stall_ang%0d", k), int'(bus.angle), a);
        end
        @(negedge clock) bus.in_valid = 1'b0;
        consume();
        chk_eq("stall_release_ready", int'(bus.in_ready), 1);
        chk_eq("stall_release_valid", int'(bus.out_valid), 0);

        @(negedge clock);
        bus.x_in = 16'sh2000;
        bus.y_in = 16'sh1000;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        chk_eq("midrst_out_valid", int'(bus.out_valid), 0);
        chk_eq("midrst_in_ready", int'(bus.in_ready), 1);
        chk_eq("midrst_mag", int'(bus.magnitude), 0);
        chk_eq("midrst_angle", int'(bus.angle), 0);
        @(negedge clock) reset = 1'b1;
        run(-16'sh1234, 16'sh2345, MTOL);

        for (int k = 0; k < 24; k++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ((rx < 0 ? -int'(rx) : int'(rx)) + (ry < 0 ? -int'(ry) : int'(ry)) < 2048) rx = 16'sh2000;
            run(rx, ry, MTOL);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
